// File: rtl/adc_spi_responder.sv
// Serial-side model of a 12-bit SPI ADC. A CONVST rise latches a sample and waits out the
// conversion delay. The sample then shifts out MSB-first on SDO while a config word is read in on SDI.
module adc_spi_responder #(
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned CONF_W      = 6,
  parameter int unsigned CONV_CYCLES = 2,
  parameter int unsigned SYNC_STAGES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              adc_sck,
  input  logic              adc_convst,
  input  logic              adc_sdi,
  output logic              adc_sdo,
  input  logic [DATA_W-1:0] sample_in,
  output logic [CONF_W-1:0] conf_out,
  output logic              conf_valid,
  output logic              frame_done,
  output logic              busy,
  output logic              protocol_err
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);
  localparam int unsigned CvW  = (CONV_CYCLES < 2) ? 1 : $clog2(CONV_CYCLES + 1);
  localparam logic [CntW-1:0] ConfLast = CntW'(CONF_W - 1);
  localparam logic [CntW-1:0] DataEnd  = CntW'(DATA_W);

  typedef enum logic [1:0] {StIdle, StConv, StShift} state_e;

  logic [2:0] raw_in, sync_in;
  logic       s_sck, s_convst, s_sdi;
  logic       sck_d1_q, convst_d1_q;
  logic       sck_rise, convst_rise;

  state_e            state_q;
  logic [DATA_W-2:0] shift_q;   // bits still to be sent after the one on adc_sdo
  logic [CONF_W-1:0] conf_sr_q;
  logic [CntW-1:0]   bit_cnt_q;
  logic [CvW-1:0]    conv_cnt_q;
  logic              conf_pend_q;

  assign raw_in = {adc_sck, adc_convst, adc_sdi};

  if (SYNC_STAGES == 0) begin : g_nosync
    assign sync_in = raw_in;
  end else begin : g_sync
    logic [2:0] stage_q [SYNC_STAGES];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < int'(SYNC_STAGES); i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= raw_in;
        for (int i = 1; i < int'(SYNC_STAGES); i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign sync_in = stage_q[SYNC_STAGES-1];
  end

  assign s_sck       = sync_in[2];
  assign s_convst    = sync_in[1];
  assign s_sdi       = sync_in[0];
  assign sck_rise    = s_sck & ~sck_d1_q;
  assign convst_rise = s_convst & ~convst_d1_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      conf_sr_q    <= '0;
      bit_cnt_q    <= '0;
      conv_cnt_q   <= '0;
      conf_pend_q  <= 1'b0;
      sck_d1_q     <= 1'b0;
      convst_d1_q  <= 1'b0;
      adc_sdo      <= 1'b0;
      conf_out     <= '0;
      conf_valid   <= 1'b0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      sck_d1_q     <= s_sck;
      convst_d1_q  <= s_convst;
      conf_valid   <= 1'b0;
      frame_done   <= 1'b0;
      protocol_err <= 1'b0;

      // A completed config word is published even if a restart lands on the same cycle.
      if (conf_pend_q) begin
        conf_out    <= conf_sr_q;
        conf_valid  <= 1'b1;
        conf_pend_q <= 1'b0;
      end

      if (convst_rise) begin
        state_q    <= StConv;
        shift_q    <= sample_in[DATA_W-2:0];
        adc_sdo    <= sample_in[DATA_W-1];
        bit_cnt_q  <= '0;
        conv_cnt_q <= CvW'(CONV_CYCLES);
        busy       <= 1'b1;
        if (state_q != StIdle) protocol_err <= 1'b1;
      end else begin
        case (state_q)
          StIdle: begin
            adc_sdo <= 1'b0;
            busy    <= 1'b0;
          end
          StConv: begin
            if (sck_rise) protocol_err <= 1'b1;
            conv_cnt_q <= conv_cnt_q - CvW'(1);
            if (conv_cnt_q <= CvW'(1)) state_q <= StShift;
          end
          StShift: begin
            if (bit_cnt_q == DataEnd) begin
              frame_done <= 1'b1;
              state_q    <= StIdle;
              busy       <= 1'b0;
              adc_sdo    <= 1'b0;
            end else if (sck_rise) begin
              if (bit_cnt_q < CntW'(CONF_W)) conf_sr_q <= {conf_sr_q[CONF_W-2:0], s_sdi};
              if (bit_cnt_q == ConfLast) conf_pend_q <= 1'b1;
              bit_cnt_q <= bit_cnt_q + CntW'(1);
              adc_sdo   <= shift_q[DATA_W-2];
              shift_q   <= {shift_q[DATA_W-3:0], 1'b0};
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Randomized scoreboard bench for adc_spi_responder: one instance with no input sync,
// one with two sync stages; a forked monitor checks every pulse against queued expectations.
module tb_adc_spi_responder;

  localparam int DW   = 12;
  localparam int CW   = 6;
  localparam int CONV = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          sck [2];
  logic          convst [2];
  logic          sdi [2];
  logic [DW-1:0] sample [2];
  logic          sdo [2];
  logic [CW-1:0] conf_out [2];
  logic          conf_valid [2];
  logic          frame_done [2];
  logic          busy [2];
  logic          perr [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    adc_spi_responder #(
      .DATA_W      (DW),
      .CONF_W      (CW),
      .CONV_CYCLES (CONV),
      .SYNC_STAGES ((g == 0) ? 0 : 2)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .adc_sck      (sck[g]),
      .adc_convst   (convst[g]),
      .adc_sdi      (sdi[g]),
      .adc_sdo      (sdo[g]),
      .sample_in    (sample[g]),
      .conf_out     (conf_out[g]),
      .conf_valid   (conf_valid[g]),
      .frame_done   (frame_done[g]),
      .busy         (busy[g]),
      .protocol_err (perr[g])
    );
  end

  int            total = 0;
  int            bad = 0;
  int            exp_err = 0;
  logic [CW-1:0] exp_conf [$];
  logic [DW-1:0] exp_data [$];
  bit            in_frame [2];
  logic [CW-1:0] model_conf [2];
  logic [DW-1:0] rx [2];
  logic          sck_prev [2];

  function automatic int syn(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Samples just after each falling clk edge: inputs change on that edge, outputs are stable.
  task automatic monitor();
    logic [CW-1:0] ec;
    logic [DW-1:0] ed;
    forever begin
      @(negedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        if (sck[d] && !sck_prev[d]) rx[d] = {rx[d][DW-2:0], sdo[d]};
        sck_prev[d] = sck[d];
        if (conf_valid[d]) begin
          if (exp_conf.size() == 0) begin
            total++; bad++;
            $display("FAIL conf_valid dut%0d: got pulse conf=%0h expected none", d, conf_out[d]);
          end else begin
            ec = exp_conf.pop_front();
            chk($sformatf("conf_out dut%0d", d), 32'(conf_out[d]), 32'(ec));
          end
        end
        if (frame_done[d]) begin
          if (exp_data.size() == 0) begin
            total++; bad++;
            $display("FAIL frame_done dut%0d: got pulse data=%0h expected none", d, rx[d]);
          end else begin
            ed = exp_data.pop_front();
            chk($sformatf("sdo word dut%0d", d), 32'(rx[d]), 32'(ed));
            chk($sformatf("idle busy/sdo dut%0d", d), 32'({busy[d], sdo[d]}), 32'd0);
          end
        end
        if (perr[d]) begin
          total++;
          if (exp_err == 0) begin
            bad++;
            $display("FAIL protocol_err dut%0d: got pulse expected none", d);
          end else begin
            exp_err--;
          end
        end
      end
    end
  endtask

  // One frame from the controller side; nbits < DW leaves the frame unfinished.
  task automatic frame(input int d, input logic [DW-1:0] smp, input logic [CW-1:0] cf,
                       input int half, input int nbits, input bit early);
    sample[d] = smp;
    if (in_frame[d]) exp_err++;
    convst[d]   = 1'b1;
    in_frame[d] = 1'b1;
    if (early) begin
      wait_clk(1);
      sck[d] = 1'b1;
      exp_err++;
      wait_clk(half);
      sck[d] = 1'b0;
      wait_clk(half);
    end
    wait_clk(CONV + 2);
    convst[d] = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      sdi[d] = (i < CW) ? cf[CW-1-i] : 1'($urandom);
      wait_clk(half);
      sck[d] = 1'b1;
      if (i == CW - 1) begin
        exp_conf.push_back(cf);
        model_conf[d] = cf;
      end
      if (i == DW - 1) exp_data.push_back(smp);
      wait_clk(half);
      sck[d] = 1'b0;
    end
    if (nbits == DW) begin
      wait_clk(half + syn(d) + 4);
      in_frame[d] = 1'b0;
    end
  endtask

  initial begin
    int h, nb;
    bit early;
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      sck[d] = 1'b0; convst[d] = 1'b0; sdi[d] = 1'b0; sample[d] = '0;
      in_frame[d] = 1'b0; model_conf[d] = '0; rx[d] = '0; sck_prev[d] = 1'b0;
    end
    fork
      monitor();
    join_none

    // Reset held while inputs toggle
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        sck[d] = 1'($urandom); convst[d] = 1'($urandom); sdi[d] = 1'($urandom);
        sample[d] = 12'($urandom);
      end
      #1;
      for (int d = 0; d < 2; d++)
        chk($sformatf("reset outputs dut%0d", d),
            32'({sdo[d], conf_out[d], conf_valid[d], frame_done[d], busy[d], perr[d]}), 32'd0);
    end
    for (int d = 0; d < 2; d++) begin
      sck[d] = 1'b0; convst[d] = 1'b0; sdi[d] = 1'b0;
    end
    wait_clk(3);
    reset = 1'b1;
    wait_clk(3);

    // Directed frames
    frame(0, 12'hA5C, 6'b100010, 1, DW, 1'b0);
    chk("conf_out after A5C", 32'(conf_out[0]), 32'h22);
    frame(0, 12'hA5C, 6'h2D, 1, DW, 1'b1);
    frame(0, 12'hFFF, 6'h15, 1, 5, 1'b0);
    chk("conf_out kept on abort", 32'(conf_out[0]), 32'(model_conf[0]));
    frame(0, 12'h001, 6'h0C, 1, DW, 1'b0);
    frame(1, 12'h800, 6'h3F, 3, DW, 1'b0);
    frame(1, 12'h7FF, 6'h00, 3, DW, 1'b0);
    chk("conf_out dut1 after b2b", 32'(conf_out[1]), 32'h00);

    // Reset in the middle of a frame
    frame(0, 12'($urandom), 6'($urandom), 1, 8, 1'b0);
    wait_clk(3);
    reset = 1'b0;
    #1;
    chk("mid-frame reset dut0",
        32'({sdo[0], conf_out[0], conf_valid[0], frame_done[0], busy[0], perr[0]}), 32'd0);
    exp_conf.delete();
    exp_data.delete();
    exp_err = 0;
    for (int d = 0; d < 2; d++) begin
      in_frame[d] = 1'b0; model_conf[d] = '0; sck[d] = 1'b0; convst[d] = 1'b0;
    end
    wait_clk(2);
    reset = 1'b1;
    wait_clk(3);
    frame(0, 12'h123, 6'($urandom), 1, DW, 1'b0);

    // Random frames, aborts and early clocks on both instances
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 12; n++) begin
        h     = syn(d) + 1 + int'($urandom_range(2));
        nb    = ($urandom_range(3) == 0) ? int'($urandom_range(11, 1)) : DW;
        early = ($urandom_range(4) == 0);
        frame(d, 12'($urandom), 6'($urandom), h, nb, early);
      end
      frame(d, 12'($urandom), 6'($urandom), syn(d) + 1, DW, 1'b0);
      chk($sformatf("conf_out final dut%0d", d), 32'(conf_out[d]), 32'(model_conf[d]));
    end

    wait_clk(20);
    chk("conf pulses outstanding", 32'(exp_conf.size()), 32'd0);
    chk("frame pulses outstanding", 32'(exp_data.size()), 32'd0);
    chk("protocol_err outstanding", 32'(exp_err), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
